// File: rtl/shift_norm.sv
// shift_norm: multi-cycle normaliser, the inverse of the barrel shifter.
// It finds the left-shift amount sa that normalises d and returns sh = d << sa.
// The search is a fixed-latency binary search with one shift step per clock.
// Latency: accept at E0, steps at E1..E5, done in the cycle after E5 (WIDTH=32).
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset; wins over start
//   start  in   1      request, accepted on a rising edge while ready=1
//   d      in   WIDTH  word to normalise, sampled on the accept edge
//   arith  in   1      0: count leading zeros, 1: count redundant sign bits
//   ready  out  1      idle and able to accept start
//   done   out  1      single-cycle pulse; sh/sa/zero valid from this cycle on
//   sh     out  WIDTH  normalised word d << sa (zero fill)
//   sa     out  SAW    shift amount 0..WIDTH
//   zero   out  1      arith=0 and d==0
module shift_norm #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SAW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             arith,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sh,
    output logic [SAW-1:0]   sa,
    output logic             zero
);

    localparam int unsigned STEPS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;

    // Working copy of the word, captured mode, running count and step index.
    logic [WIDTH-1:0] w, w_nx;
    logic             mode, mode_nx;
    logic [SAW-1:0]   cnt, cnt_nx;
    logic [SAW-1:0]   k, k_nx;

    logic             ready_nx;
    logic             done_nx;
    logic [WIDTH-1:0] sh_nx;
    logic [SAW-1:0]   sa_nx;
    logic             zero_nx;

    // Single search step for the current k.
    logic [SAW-1:0]   n;
    logic [WIDTH-1:0] mask_z;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] sgn_diff;
    logic             take;
    logic [WIDTH-1:0] w_step;
    logic [SAW-1:0]   cnt_step;

    // One binary-search step: shift by n = 2^k when the top field is redundant.
    // Zero mode tests the top n bits for zero; sign mode tests that the top
    // n+1 bits all match the MSB, done by XORing against the sign and
    // testing the same field for zero.
    always_comb begin
        n        = SAW'(1) << k;
        mask_z   = ~({WIDTH{1'b1}} >> n);
        mask_s   = ~({WIDTH{1'b1}} >> (n + SAW'(1)));
        sgn_diff = w ^ {WIDTH{w[WIDTH-1]}};
        if (mode) begin
            take = ((sgn_diff & mask_s) == '0);
        end else begin
            take = ((w & mask_z) == '0);
        end
        w_step   = take ? (w << n) : w;
        cnt_step = take ? (cnt + n) : cnt;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx = state;
        w_nx     = w;
        mode_nx  = mode;
        cnt_nx   = cnt;
        k_nx     = k;
        ready_nx = 1'b0;
        done_nx  = 1'b0;
        sh_nx    = sh;
        sa_nx    = sa;
        zero_nx  = zero;

        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                if (start) begin
                    w_nx     = d;
                    mode_nx  = arith;
                    cnt_nx   = '0;
                    k_nx     = SAW'(STEPS - 1);
                    state_nx = RUN;
                    ready_nx = 1'b0;
                end
            end

            RUN: begin
                w_nx   = w_step;
                cnt_nx = cnt_step;
                if (k == '0) begin
                    // Last step: publish the result. In zero mode a zero
                    // word stays zero through every step, so w_step==0 is
                    // equivalent to d==0.
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    sh_nx    = w_step;
                    zero_nx  = !mode && (w_step == '0);
                    sa_nx    = zero_nx ? SAW'(WIDTH) : cnt_step;
                end else begin
                    k_nx = k - SAW'(1);
                end
            end

            DONE: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end

            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
            k     <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            sh    <= '0;
            sa    <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_nx;
            w     <= w_nx;
            mode  <= mode_nx;
            cnt   <= cnt_nx;
            k     <= k_nx;
            ready <= ready_nx;
            done  <= done_nx;
            sh    <= sh_nx;
            sa    <= sa_nx;
            zero  <= zero_nx;
        end
    end

endmodule

// File: tb/tb_shift_norm.sv
// Testbench for shift_norm: directed vectors plus random words checked by a
// scoreboard; a monitor pops and compares on every done pulse.
module tb_shift_norm;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SAW   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] d;
    logic             arith;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sh;
    logic [SAW-1:0]   sa;
    logic             zero;

    shift_norm #(.WIDTH(WIDTH), .SAW(SAW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d     (d),
        .arith (arith),
        .ready (ready),
        .done  (done),
        .sh    (sh),
        .sa    (sa),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             a;
        logic [WIDTH-1:0] sh;
        logic [SAW-1:0]   sa;
        logic             z;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] mon_inv;
    logic [WIDTH-1:0] last_sh = '0;
    int               n_vec = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: linear scan from the MSB, independent of the binary search.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] dv, input logic av);
        exp_t e;
        int   c;
        c = 0;
        e.d = dv;
        e.a = av;
        if (!av) begin
            while (c < int'(WIDTH) && dv[WIDTH-1-c] == 1'b0) c++;
            e.z  = (c == int'(WIDTH));
            e.sa = SAW'(c);
            e.sh = (c == int'(WIDTH)) ? '0 : (dv << c);
        end else begin
            while (c < int'(WIDTH) - 1 && dv[WIDTH-2-c] == dv[WIDTH-1]) c++;
            e.z  = 1'b0;
            e.sa = SAW'(c);
            e.sh = dv << c;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 with empty scoreboard (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("sh", 64'(sh), 64'(mon_e.sh));
                check("sa", 64'(sa), 64'(mon_e.sa));
                check("zero", 64'(zero), 64'(mon_e.z));
                check("ready_in_done", 64'(ready), 64'(0));
                mon_inv = mon_e.d << sa;
                check("inv_shift", 64'(sh), 64'(mon_inv));
                if (!mon_e.a && mon_e.d != '0)
                    check("inv_msb", 64'(sh[WIDTH-1]), 64'(1));
                if (mon_e.a && mon_e.d != '0 && mon_e.d != '1)
                    check("inv_sign", 64'(sh[WIDTH-1] ^ sh[WIDTH-2]), 64'(1));
            end
        end
    end

    task automatic wait_ready();
        int b;
        b = 0;
        while (ready !== 1'b1 && b < 40) begin
            @(negedge clk);
            b++;
        end
        if (ready !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, b);
        end
    endtask

    // Accept one op at the next rising edge; returns at the negedge after it.
    task automatic issue(input logic [WIDTH-1:0] dv, input logic av,
                         input logic [WIDTH-1:0] esh, input logic [SAW-1:0] esa, input logic ez);
        exp_t e;
        wait_ready();
        d     = dv;
        arith = av;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d     = $urandom;
        arith = 1'($urandom);
        e.d  = dv;
        e.a  = av;
        e.sh = esh;
        e.sa = esa;
        e.z  = ez;
        sb.push_back(e);
    endtask

    // Issue and also check latency, busy ready and result hold until E5.
    task automatic issue_timed(input logic [WIDTH-1:0] dv, input logic av,
                               input logic [WIDTH-1:0] esh, input logic [SAW-1:0] esa, input logic ez);
        issue(dv, av, esh, esa, ez);
        for (int i = 0; i < 5; i++) begin
            check("lat_done_low", 64'(done), 64'(0));
            check("lat_ready_low", 64'(ready), 64'(0));
            check("hold_sh", 64'(sh), 64'(last_sh));
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        check("lat_done_high", 64'(done), 64'(1));
        @(negedge clk);
        check("lat_done_pulse", 64'(done), 64'(0));
        check("lat_ready_back", 64'(ready), 64'(1));
        last_sh = esh;
    endtask

    initial begin
        exp_t             e;
        logic [WIDTH-1:0] rv;
        logic             ra;
        int               b;

        rst   = 1'b1;
        start = 1'b0;
        d     = '0;
        arith = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sh", 64'(sh), 64'(0));
        check("rst_sa", 64'(sa), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));

        // Directed vectors with hand-computed results.
        issue_timed(32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0);
        issue_timed(32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
        issue_timed(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 6'd0,  1'b0);
        issue(32'hFFFF_8000, 1'b1, 32'h8000_0000, 6'd16, 1'b0);
        issue(32'h0000_0001, 1'b1, 32'h4000_0000, 6'd30, 1'b0);
        issue(32'h8000_0000, 1'b1, 32'h8000_0000, 6'd0,  1'b0);
        issue(32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b0);
        issue(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
        issue(32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0);
        issue(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 6'd0,  1'b0);
        issue(32'h4000_0000, 1'b0, 32'h8000_0000, 6'd1,  1'b0);
        issue(32'h0012_3400, 1'b1, 32'h48D0_0000, 6'd10, 1'b0);

        // start held high, d changing every cycle: accepts only at E0, E7, E14.
        wait_ready();
        start = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            d     = 32'h1 << i;
            arith = 1'b0;
            if (i == 0 || i == 7 || i == 14) begin
                e.d  = d;
                e.a  = 1'b0;
                e.sh = 32'h8000_0000;
                e.sa = (i == 0) ? 6'd31 : (i == 7) ? 6'd24 : 6'd17;
                e.z  = 1'b0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;

        // Reset at E3 of an op (with start also high): abort, no done pulse.
        wait_ready();
        d     = 32'h0000_0300;
        arith = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sh", 64'(sh), 64'(0));
        check("abort_sa", 64'(sa), 64'(0));
        check("abort_zero", 64'(zero), 64'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(0));
        end
        last_sh = '0;
        issue_timed(32'h0000_0300, 1'b0, 32'hC000_0000, 6'd22, 1'b0);

        // Random words, biased towards long leading runs.
        for (int i = 0; i < 1500; i++) begin
            rv = $urandom;
            case ($urandom_range(0, 3))
                1: rv = rv >> $urandom_range(0, 31);
                2: rv = ~(rv >> $urandom_range(0, 31));
                3: rv = $urandom_range(0, 1) ? '0 : '1;
                default: ;
            endcase
            ra = 1'($urandom);
            e  = ref_model(rv, ra);
            issue(rv, ra, e.sh, e.sa, e.z);
        end

        // Drain the scoreboard with a bounded wait.
        b = 0;
        while (sb.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
